// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer
//   Consumer end of the drawer pixel-plot interface. Plotted pixels are captured into a small
//   FIFO as {linear address, colour} and drained into the frame-buffer write port on granted
//   cycles. Also performs a full-screen clear and reports when a finished frame is committed.
// Ports
//   clock, reset          : system clock (rising edge), asynchronous active-low reset
//   x_counter, y_counter  : pixel coordinates from the drawer
//   colour, plot          : pixel colour and valid (no backpressure)
//   iDone                 : drawer frame-done level
//   iClear, clear_colour  : single-cycle clear request and its fill colour
//   fb_grant              : arbiter grants the RAM write port this cycle
//   fb_address/data/wren  : registered RAM write port
//   busy                  : clearing or FIFO non-empty
//   frame_written         : one-cycle pulse once a finished frame is fully committed
//   overflow, oob_count   : sticky drop flag and saturating out-of-range drop count
module fb_pixel_writer #(
  parameter int unsigned X_SCREEN_PIXELS = 160,
  parameter int unsigned Y_SCREEN_PIXELS = 120,
  parameter int unsigned FIFO_DEPTH      = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  x_counter,
  input  logic [6:0]  y_counter,
  input  logic [2:0]  colour,
  input  logic        plot,
  input  logic        iDone,
  input  logic        iClear,
  input  logic [2:0]  clear_colour,
  input  logic        fb_grant,
  output logic [14:0] fb_address,
  output logic [2:0]  fb_data,
  output logic        fb_wren,
  output logic        busy,
  output logic        frame_written,
  output logic        overflow,
  output logic [7:0]  oob_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [7:0]  XLimit   = 8'(X_SCREEN_PIXELS);
  localparam logic [6:0]  YLimit   = 7'(Y_SCREEN_PIXELS);
  localparam logic [14:0] LastAddr = 15'(X_SCREEN_PIXELS * Y_SCREEN_PIXELS - 1);
  localparam logic [PtrW:0]   CntFull = (PtrW + 1)'(FIFO_DEPTH);
  localparam logic [PtrW:0]   CntOne  = (PtrW + 1)'(1);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

  typedef enum logic [1:0] {StIdle, StWrite, StClear} state_e;

  state_e          state_q, state_d;
  logic [17:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic [14:0]     clr_addr_q, clr_addr_d;
  logic [2:0]      clr_colour_q, clr_colour_d;
  logic [14:0]     fb_address_q, fb_address_d;
  logic [2:0]      fb_data_q, fb_data_d;
  logic            fb_wren_q, fb_wren_d;
  logic            frame_written_q, frame_written_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      oob_count_q, oob_count_d;
  logic            pending_q, pending_d;
  logic            done_q;

  logic        in_range, full, push, pop, fire;
  logic [14:0] pix_addr;
  logic [17:0] head;

  // y*160 + x as shifts; the address fits 15 bits for every in-range pixel.
  assign pix_addr = 15'({y_counter, 7'b0}) + 15'({y_counter, 5'b0}) + 15'(x_counter);
  assign in_range = (x_counter < XLimit) && (y_counter < YLimit);
  assign full     = (count_q == CntFull);
  assign head     = mem_q[rd_ptr_q];
  assign pop      = (state_q == StWrite) && fb_grant && (count_q != '0);
  // A full FIFO still accepts a pixel when an entry leaves on the same edge.
  assign push     = plot && in_range && (!full || pop);
  // Last write is already on the port once the FIFO reads empty.
  assign fire     = pending_q && (state_q != StClear) && (count_q == '0) && !push && !iClear;

  always_comb begin
    wr_ptr_d        = push ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d        = pop ? rd_ptr_q + PtrOne : rd_ptr_q;
    count_d         = count_q;
    if (push && !pop) count_d = count_q + CntOne;
    if (pop && !push) count_d = count_q - CntOne;

    overflow_d      = overflow_q | (plot && in_range && !push);
    oob_count_d     = oob_count_q;
    if (plot && !in_range && (oob_count_q != 8'hFF)) oob_count_d = oob_count_q + 8'd1;

    pending_d       = (iDone && !done_q) || (pending_q && !fire);
    frame_written_d = fire;

    state_d         = state_q;
    clr_addr_d      = clr_addr_q;
    clr_colour_d    = clr_colour_q;
    fb_wren_d       = 1'b0;
    fb_address_d    = fb_address_q;
    fb_data_d       = fb_data_q;

    unique case (state_q)
      StIdle: begin
        if (push) state_d = StWrite;
      end
      StWrite: begin
        if (pop) begin
          fb_wren_d    = 1'b1;
          fb_address_d = head[17:3];
          fb_data_d    = head[2:0];
        end
        if (count_d == '0) state_d = StIdle;
      end
      StClear: begin
        if (fb_grant) begin
          fb_wren_d    = 1'b1;
          fb_address_d = clr_addr_q;
          fb_data_d    = clr_colour_q;
          if (clr_addr_q == LastAddr) begin
            state_d = (count_d != '0) ? StWrite : StIdle;
          end else begin
            clr_addr_d = clr_addr_q + 15'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A clear request (re)starts the sweep from address 0 in any state.
    if (iClear) begin
      state_d      = StClear;
      clr_addr_d   = '0;
      clr_colour_d = clear_colour;
      overflow_d   = 1'b0;
      oob_count_d  = '0;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {pix_addr, colour};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= StIdle;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      clr_addr_q      <= '0;
      clr_colour_q    <= '0;
      fb_address_q    <= '0;
      fb_data_q       <= '0;
      fb_wren_q       <= 1'b0;
      frame_written_q <= 1'b0;
      overflow_q      <= 1'b0;
      oob_count_q     <= '0;
      pending_q       <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      clr_addr_q      <= clr_addr_d;
      clr_colour_q    <= clr_colour_d;
      fb_address_q    <= fb_address_d;
      fb_data_q       <= fb_data_d;
      fb_wren_q       <= fb_wren_d;
      frame_written_q <= frame_written_d;
      overflow_q      <= overflow_d;
      oob_count_q     <= oob_count_d;
      pending_q       <= pending_d;
      done_q          <= iDone;
    end
  end

  assign fb_address    = fb_address_q;
  assign fb_data       = fb_data_q;
  assign fb_wren       = fb_wren_q;
  assign busy          = (state_q == StClear) || (count_q != '0);
  assign frame_written = frame_written_q;
  assign overflow      = overflow_q;
  assign oob_count     = oob_count_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
module tb_fb_pixel_writer;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  x_counter;
  logic [6:0]  y_counter;
  logic [2:0]  colour;
  logic        plot;
  logic        iDone;
  logic        iClear;
  logic [2:0]  clear_colour;
  logic        fb_grant;
  logic [14:0] fb_address;
  logic [2:0]  fb_data;
  logic        fb_wren;
  logic        busy;
  logic        frame_written;
  logic        overflow;
  logic [7:0]  oob_count;

  int n_tests = 0;
  int n_fail  = 0;

  fb_pixel_writer dut (
    .clock        (clock),
    .reset        (reset),
    .x_counter    (x_counter),
    .y_counter    (y_counter),
    .colour       (colour),
    .plot         (plot),
    .iDone        (iDone),
    .iClear       (iClear),
    .clear_colour (clear_colour),
    .fb_grant     (fb_grant),
    .fb_address   (fb_address),
    .fb_data      (fb_data),
    .fb_wren      (fb_wren),
    .busy         (busy),
    .frame_written(frame_written),
    .overflow     (overflow),
    .oob_count    (oob_count)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw, np, wat, errs;
    reset = 1'b0; x_counter = '0; y_counter = '0; colour = '0; plot = 1'b0;
    iDone = 1'b0; iClear = 1'b0; clear_colour = '0; fb_grant = 1'b1;
    step(); step();
    check_eq("rst_wren", 32'(fb_wren), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_fw", 32'(frame_written), 0);
    check_eq("rst_ovf", 32'(overflow), 0);
    check_eq("rst_oob", 32'(oob_count), 0);
    check_eq("rst_addr", 32'(fb_address), 0);
    reset = 1'b1;
    step();

    // 1) single pixel: captured at one edge, written after the next
    x_counter = 8'd5; y_counter = 7'd2; colour = 3'b100; plot = 1'b1;
    step();
    plot = 1'b0;
    check_eq("t1_no_early_wren", 32'(fb_wren), 0);
    step();
    check_eq("t1_wren", 32'(fb_wren), 1);
    check_eq("t1_addr", 32'(fb_address), 325);
    check_eq("t1_data", 32'(fb_data), 3'b100);
    step();
    check_eq("t1_single_wren", 32'(fb_wren), 0);
    check_eq("t1_idle_busy", 32'(busy), 0);

    // 2) bottom-right corner, then out-of-range drops and saturation
    x_counter = 8'd159; y_counter = 7'd119; colour = 3'b011; plot = 1'b1;
    step();
    plot = 1'b0;
    step();
    check_eq("t2_corner_wren", 32'(fb_wren), 1);
    check_eq("t2_corner_addr", 32'(fb_address), 19199);
    x_counter = 8'd160; y_counter = 7'd0; plot = 1'b1;
    step();
    plot = 1'b0;
    check_eq("t2_oob_one", 32'(oob_count), 1);
    step();
    check_eq("t2_oob_no_write", 32'(fb_wren), 0);
    x_counter = 8'd10; y_counter = 7'd120; plot = 1'b1;
    repeat (300) step();
    plot = 1'b0;
    check_eq("t2_oob_sat", 32'(oob_count), 255);
    check_eq("t2_oob_busy", 32'(busy), 0);

    // 3) no grant: 10 plots, 8 kept, then drained in order
    fb_grant = 1'b0;
    for (int i = 0; i < 10; i++) begin
      x_counter = 8'(i); y_counter = 7'd1; colour = 3'(i); plot = 1'b1;
      step();
    end
    plot = 1'b0;
    check_eq("t3_overflow", 32'(overflow), 1);
    check_eq("t3_busy", 32'(busy), 1);
    check_eq("t3_no_wren", 32'(fb_wren), 0);
    fb_grant = 1'b1;
    nw = 0;
    for (int c = 0; c < 14; c++) begin
      step();
      if (fb_wren) begin
        check_eq("t3_addr", 32'(fb_address), 32'(160 + nw));
        check_eq("t3_data", 32'(fb_data), 32'(nw % 8));
        nw++;
      end
    end
    check_eq("t3_write_count", 32'(nw), 8);
    check_eq("t3_ovf_sticky", 32'(overflow), 1);

    // 4) full-screen clear
    clear_colour = 3'b001; iClear = 1'b1;
    step();
    iClear = 1'b0; clear_colour = 3'b111;
    check_eq("t4_ovf_cleared", 32'(overflow), 0);
    check_eq("t4_oob_cleared", 32'(oob_count), 0);
    check_eq("t4_busy", 32'(busy), 1);
    nw = 0; errs = 0;
    for (int c = 0; c < 20000; c++) begin
      step();
      if (fb_wren) begin
        if (fb_address != 15'(nw) || fb_data != 3'b001) errs++;
        nw++;
      end
      if (!busy) break;
    end
    check_eq("t4_seq_errs", 32'(errs), 0);
    check_eq("t4_write_count", 32'(nw), 19200);
    check_eq("t4_busy_drop", 32'(busy), 0);
    step();
    check_eq("t4_done_wren", 32'(fb_wren), 0);

    // 5) stream 20 pixels with irregular grant, then iDone held high
    nw = 0; np = 0; wat = -1;
    for (int c = 0; c < 120; c++) begin
      plot      = (c < 40) && (c % 2 == 0);
      x_counter = 8'(c / 2);
      y_counter = 7'd3;
      colour    = 3'(c / 2);
      fb_grant  = (c % 3) != 0;
      iDone     = (c >= 41);
      step();
      if (fb_wren) begin
        check_eq("t5_addr", 32'(fb_address), 32'(480 + nw));
        nw++;
      end
      if (frame_written) begin
        np++;
        wat = nw;
      end
    end
    plot = 1'b0; iDone = 1'b0; fb_grant = 1'b1;
    check_eq("t5_write_count", 32'(nw), 20);
    check_eq("t5_pulse_count", 32'(np), 1);
    check_eq("t5_pulse_after_last", 32'(wat), 20);

    // 6) reset in the middle of a clear
    clear_colour = 3'b010; iClear = 1'b1;
    step();
    iClear = 1'b0;
    nw = 0;
    for (int c = 0; c < 6000; c++) begin
      step();
      if (fb_wren && fb_address == 15'd5000) begin
        nw = 1;
        break;
      end
    end
    check_eq("t6_reached_5000", 32'(nw), 1);
    reset = 1'b0;
    #1;
    check_eq("t6_wren_now", 32'(fb_wren), 0);
    check_eq("t6_busy_now", 32'(busy), 0);
    check_eq("t6_fw_now", 32'(frame_written), 0);
    check_eq("t6_addr_now", 32'(fb_address), 0);
    step();
    reset = 1'b1;
    step(); step();
    check_eq("t6_wren_after", 32'(fb_wren), 0);
    check_eq("t6_busy_after", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
